// File: rtl/regfile_scan_reader_if.sv
// Output beat stream of the register-file scan reader: one register value
// tagged with its index, moved under a valid/ready handshake.
interface regfile_scan_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Handshake: the producer raises out_valid with out_data/out_reg and keeps
  // all three stable until a cycle where out_ready is also high; that rising
  // edge transfers the beat. out_ready may change freely and never depends on
  // a later beat.
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_reg;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_reg, output out_valid, input out_ready);
  modport slave  (input out_data, input out_reg, input out_valid, output out_ready);
endinterface

// File: rtl/regfile_scan_reader.sv
// Walks a wrapping range of register indices through one register-file read
// port and streams each value out, tagged with its index.
module regfile_scan_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    first_reg,
  input  logic [ADDR_W-1:0]    last_reg,
  output logic [ADDR_W-1:0]    rf_read_reg,
  input  logic [DATA_W-1:0]    rf_read_data,
  input  logic                 rf_reg_write,
  input  logic [ADDR_W-1:0]    rf_write_reg,
  input  logic [DATA_W-1:0]    rf_write_data,
  regfile_scan_reader_if.master stream,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_reg_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              bypass_hit;

  // A write landing on the index being read this cycle has not reached the
  // array yet, so its data is forwarded instead of the stale read value.
  assign bypass_hit = rf_reg_write && (rf_write_reg == cur);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_reg_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur    <= first_reg;
            last_q <= last_reg;
            busy_q <= 1'b1;
            state  <= READ;
          end
        end
        READ: begin
          out_data_q  <= bypass_hit ? rf_write_data : rf_read_data;
          out_reg_q   <= cur;
          out_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (stream.out_ready) begin
            out_valid_q <= 1'b0;
            if (cur == last_q) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              // Index arithmetic wraps naturally at the ADDR_W boundary.
              cur   <= cur + ADDR_W'(1);
              state <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rf_read_reg      = cur;
  assign stream.out_data  = out_data_q;
  assign stream.out_reg   = out_reg_q;
  assign stream.out_valid = out_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Self-checking bench for regfile_scan_reader: a behavioural register file,
// a beat collector and per-scenario tasks that compare against range rules.
module tb_regfile_scan_reader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start;
  logic [ADDR_W-1:0] first_reg, last_reg;
  logic [ADDR_W-1:0] rf_read_reg;
  logic [DATA_W-1:0] rf_read_data;
  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              busy, done;
  logic [1:0]        state_dbg;

  regfile_scan_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sif ();

  regfile_scan_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .first_reg    (first_reg),
    .last_reg     (last_reg),
    .rf_read_reg  (rf_read_reg),
    .rf_read_data (rf_read_data),
    .rf_reg_write (rf_reg_write),
    .rf_write_reg (rf_write_reg),
    .rf_write_data(rf_write_data),
    .stream       (sif),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // ---------------- behavioural register file ----------------
  logic [DATA_W-1:0] rf_mem [NREG];
  assign rf_read_data = rf_mem[rf_read_reg];
  always @(posedge clk) if (rf_reg_write) rf_mem[rf_write_reg] <= rf_write_data;

  // Write driver: fires a write while the reader is reading byp_watch
  // (busy, no beat on the output yet, read port pointing at that index).
  logic              byp_en;
  logic [ADDR_W-1:0] byp_watch, byp_reg;
  logic [DATA_W-1:0] byp_val;
  always @(negedge clk) begin
    if (byp_en && busy && !sif.out_valid && rf_read_reg == byp_watch) begin
      rf_reg_write  = 1'b1;
      rf_write_reg  = byp_reg;
      rf_write_data = byp_val;
    end else begin
      rf_reg_write  = 1'b0;
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] exp_reg_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] obs_reg_q[$];
  logic [DATA_W-1:0] obs_data_q[$];
  int                obs_cyc_q[$];
  int done_cnt, done_cyc, stall_viol, busy_drop, first_valid_cyc;
  logic busy_at_done;
  bit timed_out;

  // Reference: beats are first, first+1, ... last modulo NREG, each carrying
  // the register contents as they stand when the scan is set up.
  function automatic void build_expected(input int f, input int l);
    int n;
    n = ((l - f + NREG) % NREG) + 1;
    exp_reg_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_reg_q.push_back(ADDR_W'((f + i) % NREG));
      exp_q.push_back(rf_mem[(f + i) % NREG]);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start(input int f, input int l);
    first_reg = ADDR_W'(f);
    last_reg  = ADDR_W'(l);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Collects beats until done (plus tail cycles). mode 0: ready high,
  // 1: ready 0,0,1 per beat, 2: random ready. inj_after >= 0 pulses a
  // stray start once that many beats have been accepted.
  task automatic collect(input int mode, input int inj_after, input int tail, input int max_cyc);
    int cyc, stall, tail_left;
    bit held, injected, done_seen;
    logic rdy;
    logic [DATA_W-1:0] pd;
    logic [ADDR_W-1:0] pr;
    obs_reg_q.delete(); obs_data_q.delete(); obs_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; stall_viol = 0; busy_drop = 0;
    first_valid_cyc = -1; busy_at_done = 1'bx; timed_out = 0;
    cyc = 0; stall = 0; held = 0; injected = 0; done_seen = 0; tail_left = tail;
    pd = '0; pr = '0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (sif.out_valid) begin
        if (held && (sif.out_data !== pd || sif.out_reg !== pr)) stall_viol++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (stall >= 2);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        sif.out_ready = rdy;
        if (rdy) begin
          obs_reg_q.push_back(sif.out_reg);
          obs_data_q.push_back(sif.out_data);
          obs_cyc_q.push_back(cyc);
          held = 0; stall = 0;
        end else begin
          held = 1; stall++; pd = sif.out_data; pr = sif.out_reg;
        end
      end else begin
        held = 0;
        sif.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      if (!done_seen && !done && !busy) busy_drop++;
      if (done) begin
        done_cnt++;
        if (!done_seen) begin done_seen = 1; done_cyc = cyc; busy_at_done = busy; end
      end
      if (inj_after >= 0 && !injected && obs_reg_q.size() == inj_after) begin
        first_reg = 5'd20; last_reg = 5'd25; start = 1'b1; injected = 1;
      end
      if (done_seen) begin
        if (tail_left == 0) break;
        tail_left--;
      end
      cyc++;
      if (cyc > max_cyc) begin timed_out = 1; break; end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; first_reg = '0; last_reg = '0;
    sif.out_ready = 1'b0; byp_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sif.out_ready = 1'b0; byp_en = 1'b0;
    first_reg = '0; last_reg = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (sif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", sif.out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (sif.out_data !== '0 || sif.out_reg !== '0) begin n_fail++; $display("FAIL reset_out got %h/%0d want 0/0", sif.out_data, sif.out_reg); end
    n_checks++; if (rf_read_reg !== '0) begin n_fail++; $display("FAIL reset_rdreg got %0d want 0", rf_read_reg); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_start busy=%b valid=%b want 0/0", busy, sif.out_valid); end
  endtask

  task automatic test_full_scan();
    int bad_gap;
    for (int i = 0; i < NREG; i++) rf_mem[i] = DATA_W'(i * 3);
    do_start(0, 31);
    collect(0, -1, 3, 2000);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL full_timeout got 1 want 0"); end
    n_checks++; if (obs_reg_q.size() !== 32) begin n_fail++; $display("FAIL full_count got %0d want 32", obs_reg_q.size()); end
    for (int i = 0; i < obs_reg_q.size() && i < 32; i++) begin
      n_checks++;
      if (obs_reg_q[i] !== ADDR_W'(i) || obs_data_q[i] !== DATA_W'(i * 3)) begin
        n_fail++; $display("FAIL full_beat%0d got %0d/%0d want %0d/%0d", i, obs_reg_q[i], obs_data_q[i], i, i * 3);
      end
    end
    n_checks++; if (first_valid_cyc !== 1) begin n_fail++; $display("FAIL full_latency got %0d want 1", first_valid_cyc); end
    bad_gap = 0;
    for (int i = 1; i < obs_cyc_q.size(); i++) if (obs_cyc_q[i] - obs_cyc_q[i-1] != 2) bad_gap++;
    n_checks++; if (bad_gap !== 0) begin n_fail++; $display("FAIL full_throughput got %0d bad gaps want 0", bad_gap); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL full_done_count got %0d want 1", done_cnt); end
    if (obs_cyc_q.size() > 0) begin
      n_checks++; if (done_cyc !== obs_cyc_q[obs_cyc_q.size()-1] + 1) begin n_fail++; $display("FAIL full_done_time got %0d want %0d", done_cyc, obs_cyc_q[obs_cyc_q.size()-1] + 1); end
    end
    n_checks++; if (busy_drop !== 0) begin n_fail++; $display("FAIL full_busy_drop got %0d want 0", busy_drop); end
    n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL full_busy_at_done got %b want 0", busy_at_done); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < NREG; i++) rf_mem[i] = $urandom;
    build_expected(4, 6);
    do_start(4, 6);
    collect(1, -1, 3, 500);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout got 1 want 0"); end
    n_checks++; if (obs_reg_q.size() !== exp_reg_q.size()) begin n_fail++; $display("FAIL bp_count got %0d want %0d", obs_reg_q.size(), exp_reg_q.size()); end
    for (int i = 0; i < obs_reg_q.size() && i < exp_reg_q.size(); i++) begin
      n_checks++;
      if (obs_reg_q[i] !== exp_reg_q[i] || obs_data_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_beat%0d got %0d/%h want %0d/%h", i, obs_reg_q[i], obs_data_q[i], exp_reg_q[i], exp_q[i]);
      end
    end
    n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", stall_viol); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap_single();
    int ranges [2][2];
    ranges[0][0] = 30; ranges[0][1] = 1;
    ranges[1][0] = 7;  ranges[1][1] = 7;
    for (int r = 0; r < 2; r++) begin
      build_expected(ranges[r][0], ranges[r][1]);
      do_start(ranges[r][0], ranges[r][1]);
      collect(0, -1, 3, 500);
      n_checks++; if (obs_reg_q.size() !== exp_reg_q.size()) begin n_fail++; $display("FAIL wrap%0d_count got %0d want %0d", r, obs_reg_q.size(), exp_reg_q.size()); end
      for (int i = 0; i < obs_reg_q.size() && i < exp_reg_q.size(); i++) begin
        n_checks++;
        if (obs_reg_q[i] !== exp_reg_q[i] || obs_data_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL wrap%0d_beat%0d got %0d/%h want %0d/%h", r, i, obs_reg_q[i], obs_data_q[i], exp_reg_q[i], exp_q[i]);
        end
      end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL wrap%0d_done_count got %0d want 1", r, done_cnt); end
    end
  endtask

  task automatic test_write_bypass();
    // Write to another index during the read of 9: beat 9 keeps its value.
    build_expected(8, 10);
    byp_en = 1'b1; byp_watch = 5'd9; byp_reg = 5'd12; byp_val = 32'h1234_5678;
    do_start(8, 10);
    collect(0, -1, 2, 500);
    n_checks++; if (obs_reg_q.size() !== 3) begin n_fail++; $display("FAIL byp_other_count got %0d want 3", obs_reg_q.size()); end
    if (obs_reg_q.size() > 1) begin
      n_checks++; if (obs_data_q[1] !== exp_q[1]) begin n_fail++; $display("FAIL byp_other_beat9 got %h want %h", obs_data_q[1], exp_q[1]); end
    end
    // Write to 9 itself during its read: beat 9 carries the new data.
    build_expected(8, 10);
    exp_q[1] = 32'hDEAD_BEEF;
    byp_reg = 5'd9; byp_val = 32'hDEAD_BEEF;
    do_start(8, 10);
    collect(0, -1, 2, 500);
    byp_en = 1'b0;
    n_checks++; if (obs_reg_q.size() !== 3) begin n_fail++; $display("FAIL byp_self_count got %0d want 3", obs_reg_q.size()); end
    for (int i = 0; i < obs_reg_q.size() && i < 3; i++) begin
      n_checks++;
      if (obs_reg_q[i] !== exp_reg_q[i] || obs_data_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL byp_self_beat%0d got %0d/%h want %0d/%h", i, obs_reg_q[i], obs_data_q[i], exp_reg_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    build_expected(0, 3);
    do_start(0, 3);
    collect(0, 2, 6, 500);
    n_checks++; if (obs_reg_q.size() !== 4) begin n_fail++; $display("FAIL swb_count got %0d want 4", obs_reg_q.size()); end
    for (int i = 0; i < obs_reg_q.size() && i < 4; i++) begin
      n_checks++;
      if (obs_reg_q[i] !== exp_reg_q[i] || obs_data_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL swb_beat%0d got %0d/%h want %0d/%h", i, obs_reg_q[i], obs_data_q[i], exp_reg_q[i], exp_q[i]);
      end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL swb_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    do_start(10, 11);
    collect(0, -1, 0, 500);
    n_checks++; if (done_cnt !== 1 || obs_reg_q.size() !== 2) begin n_fail++; $display("FAIL b2b_first got %0d beats/%0d done want 2/1", obs_reg_q.size(), done_cnt); end
    // New start issued in the same cycle as the done pulse.
    build_expected(12, 12);
    do_start(12, 12);
    collect(0, -1, 3, 500);
    n_checks++; if (obs_reg_q.size() !== 1) begin n_fail++; $display("FAIL b2b_count got %0d want 1", obs_reg_q.size()); end
    if (obs_reg_q.size() > 0) begin
      n_checks++; if (obs_reg_q[0] !== 5'd12 || obs_data_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL b2b_beat got %0d/%h want 12/%h", obs_reg_q[0], obs_data_q[0], exp_q[0]); end
    end
    n_checks++; if (first_valid_cyc !== 1) begin n_fail++; $display("FAIL b2b_latency got %0d want 1", first_valid_cyc); end
  endtask

  task automatic test_reset_mid_scan();
    bit found;
    found = 0;
    do_start(0, 10);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sif.out_valid && sif.out_reg == 5'd5) begin sif.out_ready = 1'b0; found = 1; break; end
      sif.out_ready = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_reach got 0 want 1"); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_async got valid=%b busy=%b done=%b want 0/0/0", sif.out_valid, busy, done); end
    n_checks++; if (sif.out_reg !== '0 || sif.out_data !== '0) begin n_fail++; $display("FAIL rstmid_out got %0d/%h want 0/0", sif.out_reg, sif.out_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    build_expected(2, 3);
    do_start(2, 3);
    collect(0, -1, 3, 500);
    n_checks++; if (obs_reg_q.size() !== 2) begin n_fail++; $display("FAIL rstmid_count got %0d want 2", obs_reg_q.size()); end
    for (int i = 0; i < obs_reg_q.size() && i < 2; i++) begin
      n_checks++;
      if (obs_reg_q[i] !== exp_reg_q[i] || obs_data_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_beat%0d got %0d/%h want %0d/%h", i, obs_reg_q[i], obs_data_q[i], exp_reg_q[i], exp_q[i]);
      end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rstmid_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    int f, l, errs;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NREG; i++) rf_mem[i] = $urandom;
      f = $urandom_range(0, NREG - 1);
      l = $urandom_range(0, NREG - 1);
      build_expected(f, l);
      do_start(f, l);
      collect(2, -1, 2, 3000);
      n_checks++; if (timed_out || obs_reg_q.size() !== exp_reg_q.size()) begin n_fail++; $display("FAIL rand%0d_count range %0d..%0d got %0d want %0d", t, f, l, obs_reg_q.size(), exp_reg_q.size()); end
      errs = 0;
      for (int i = 0; i < obs_reg_q.size() && i < exp_reg_q.size(); i++)
        if (obs_reg_q[i] !== exp_reg_q[i] || obs_data_q[i] !== exp_q[i]) errs++;
      n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL rand%0d_beats range %0d..%0d got %0d wrong beats want 0", t, f, l, errs); end
      n_checks++; if (stall_viol !== 0 || done_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_proto got %0d changes/%0d done want 0/1", t, stall_viol, done_cnt); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rf_reg_write = 1'b0; rf_write_reg = '0; rf_write_data = '0;
    byp_en = 1'b0; byp_watch = '0; byp_reg = '0; byp_val = '0;
    for (int i = 0; i < NREG; i++) rf_mem[i] = '0;
    test_reset();
    apply_reset();
    test_full_scan();
    test_backpressure();
    test_wrap_single();
    test_write_bypass();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
